// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_pkg
//  Brief    : Shared constants and types for the store path (funct3 codes,
//             error codes, FSM encodings and store-buffer entry layout).
//  Revision : 1.0 - initial release
// ============================================================================
package store_pkg;

    // Store-width encodings carried in funct3
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Issue FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Entry field widths
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // One buffered store: word address, lane data, byte enables, byte address
    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] baddr;
    } st_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
//  Module   : store_align
//  Brief    : Combinational byte-lane alignment for stores. Replicates the
//             store data across lanes, builds byte enables and flags
//             misaligned or illegal-width stores.
//  Revision : 1.0 - initial release
// ============================================================================
module store_align
    import store_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_wdata,
    output logic [BE_W-1:0]   o_be,
    output logic              o_misalign,
    output logic              o_illegal
);

    // Decode the store width into lane data, enables and fault flags
    always_comb begin
        o_wdata    = '0;
        o_be       = '0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_SB: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            F3_SH: begin
                o_wdata    = {2{i_data[15:0]}};
                o_be       = 4'b0011 << i_addr_lo;
                o_misalign = i_addr_lo[0];
            end
            F3_SW: begin
                o_wdata    = i_data;
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : store_unit
//  Brief    : Store path stage after the store-data mux. Aligns stores,
//             buffers them in a small FIFO and issues them to data memory
//             over a req/ack handshake, reporting misaligned, illegal and
//             timed-out stores on a one-cycle error pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module store_unit
    import store_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic        sb_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    // Input alignment
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_misalign;
    logic              w_illegal;

    store_align u_align (
        .i_funct3   (st_funct3),
        .i_addr_lo  (st_addr[1:0]),
        .i_data     (st_data),
        .o_wdata    (w_wdata),
        .o_be       (w_be),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // FIFO storage and bookkeeping
    st_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic               w_full;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    st_entry_t          w_entry;
    st_entry_t          w_head;
    st_entry_t          w_head_nxt;

    // Issue FSM and memory-side registers
    logic [0:0]         r_state;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_tmo;

    // Error reporting
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [31:0]        r_err_addr;
    logic               r_pend_vld;
    logic [1:0]         r_pend_code;
    logic [31:0]        r_pend_addr;
    logic               w_in_err;
    logic [1:0]         w_in_code;

    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_accept     = st_valid && !w_full;
    assign w_push       = w_accept && !w_illegal && !w_misalign;
    assign w_in_err     = w_accept && (w_illegal || w_misalign);
    assign w_in_code    = w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);

    // A timeout fires on the TIMEOUT-th request cycle of a head without ack
    assign w_tmo = (r_state == ST_REQ) && !mem_ack &&
                   (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
    assign w_pop = (r_state == ST_REQ) && (mem_ack || w_tmo);

    assign w_entry.waddr = {st_addr[31:2], 2'b00};
    assign w_entry.wdata = w_wdata;
    assign w_entry.be    = w_be;
    assign w_entry.baddr = st_addr;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_nxt = r_mem[w_rd_ptr_nxt];

    assign st_ready  = !w_full;
    assign sb_empty  = (r_count == '0) && (r_state == ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_addr  = r_err_addr;

    // Entry storage; contents are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: loads the head into registered outputs and holds them
    // until ack or timeout. A store pushed during the last pop is picked up
    // through IDLE, since its slot is not yet readable when the pop occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= ST_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_head.waddr;
                        r_mem_wdata <= w_head.wdata;
                        r_mem_be    <= w_head.be;
                        r_tmo_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    if (w_pop) begin
                        r_tmo_cnt <= '0;
                        if (r_count > c_CNT_W'(1)) begin
                            r_mem_addr  <= w_head_nxt.waddr;
                            r_mem_wdata <= w_head_nxt.wdata;
                            r_mem_be    <= w_head_nxt.be;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Error pulse: timeout wins, a colliding input error waits one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_err_addr  <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_code <= '0;
            r_pend_addr <= '0;
        end else begin
            if (w_tmo) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
                r_err_addr <= w_head.baddr;
                if (w_in_err) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_code <= w_in_code;
                    r_pend_addr <= st_addr;
                end
            end else if (r_pend_vld) begin
                r_err       <= 1'b1;
                r_err_code  <= r_pend_code;
                r_err_addr  <= r_pend_addr;
                r_pend_vld  <= w_in_err;
                r_pend_code <= w_in_code;
                r_pend_addr <= st_addr;
            end else if (w_in_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_in_code;
                r_err_addr <= st_addr;
            end else begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_unit
//  Brief    : Directed self-checking bench for store_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic        sb_empty;

    int n_checks;
    int n_errors;

    store_unit #(.DEPTH(2), .TIMEOUT(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .err       (err),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .sb_empty  (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = v;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        mem_ack = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        check("rst_mem_req",  mem_req,   1'b0);
        check("rst_mem_addr", mem_addr,  32'h0);
        check("rst_wdata",    mem_wdata, 32'h0);
        check("rst_be",       mem_be,    4'h0);
        check("rst_err",      err,       1'b0);
        check("rst_err_code", err_code,  2'b00);
        check("rst_err_addr", err_addr,  32'h0);
        check("rst_st_ready", st_ready,  1'b1);
        check("rst_sb_empty", sb_empty,  1'b1);
        rst = 1'b0;
        tick();

        // SB to 0x1003, ack three cycles after request
        drive(1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("sb_lat_req", mem_req, 1'b0);
        tick();
        check("sb_req",   mem_req,   1'b1);
        check("sb_addr",  mem_addr,  32'h0000_1000);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_be",    mem_be,    4'b1000);
        tick();
        tick();
        mem_ack = 1'b1;
        check("sb_hold_req",   mem_req,   1'b1);
        check("sb_hold_addr",  mem_addr,  32'h0000_1000);
        check("sb_hold_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_hold_be",    mem_be,    4'b1000);
        tick();
        mem_ack = 1'b0;
        check("sb_done_req",   mem_req,  1'b0);
        check("sb_done_empty", sb_empty, 1'b1);

        // SH then SW with ack tied high: back-to-back requests
        mem_ack = 1'b1;
        drive(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        tick();
        drive(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("sh_req",   mem_req,   1'b1);
        check("sh_addr",  mem_addr,  32'h0000_2000);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_be",    mem_be,    4'b1100);
        tick();
        check("sw_req",   mem_req,   1'b1);
        check("sw_addr",  mem_addr,  32'h0000_2004);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_be",    mem_be,    4'b1111);
        tick();
        check("b2b_done_req", mem_req, 1'b0);
        mem_ack = 1'b0;
        tick();

        // Misaligned SH, then illegal funct3 (also misaligned: illegal wins)
        drive(1'b1, 3'b001, 32'h0000_2001, 32'h0000_1111);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("mis_err",      err,      1'b1);
        check("mis_code",     err_code, 2'b01);
        check("mis_addr",     err_addr, 32'h0000_2001);
        check("mis_no_req",   mem_req,  1'b0);
        tick();
        check("mis_pulse",    err,      1'b0);
        check("mis_no_req2",  mem_req,  1'b0);
        check("mis_empty",    sb_empty, 1'b1);
        drive(1'b1, 3'b011, 32'h0000_3001, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("ill_err",      err,      1'b1);
        check("ill_code",     err_code, 2'b10);
        check("ill_addr",     err_addr, 32'h0000_3001);
        tick();
        check("ill_pulse",    err,      1'b0);
        check("ill_no_req",   mem_req,  1'b0);

        // Full buffer: three SW with ack low
        drive(1'b1, 3'b010, 32'h0000_4000, 32'hA000_0000);
        check("full_rdy0", st_ready, 1'b1);
        tick();
        drive(1'b1, 3'b010, 32'h0000_4004, 32'hA000_0004);
        check("full_rdy1", st_ready, 1'b1);
        tick();
        drive(1'b1, 3'b010, 32'h0000_4008, 32'hA000_0008);
        check("full_rdy2", st_ready, 1'b0);
        check("full_addr0", mem_addr, 32'h0000_4000);
        tick();
        mem_ack = 1'b1;
        check("full_no_bypass", st_ready, 1'b0);
        tick();
        mem_ack = 1'b0;
        check("full_rdy_after_pop", st_ready, 1'b1);
        check("full_addr1", mem_addr, 32'h0000_4004);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("full_rdy_refill", st_ready, 1'b0);
        mem_ack = 1'b1;
        tick();
        check("full_addr2",  mem_addr,  32'h0000_4008);
        check("full_wdata2", mem_wdata, 32'hA000_0008);
        tick();
        mem_ack = 1'b0;
        check("full_drained", sb_empty, 1'b1);
        tick();

        // Timeout with two entries; input error collides with second timeout
        drive(1'b1, 3'b010, 32'h0000_5000, 32'h5555_0000);
        tick();
        drive(1'b1, 3'b010, 32'h0000_5004, 32'h5555_0004);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("tmo_req", mem_req, 1'b1);
        repeat (15) tick();
        check("tmo_not_yet_err",  err,      1'b0);
        check("tmo_not_yet_addr", mem_addr, 32'h0000_5000);
        tick();
        check("tmo1_err",  err,      1'b1);
        check("tmo1_code", err_code, 2'b11);
        check("tmo1_addr", err_addr, 32'h0000_5000);
        check("tmo1_next", mem_addr, 32'h0000_5004);
        check("tmo1_req",  mem_req,  1'b1);
        repeat (15) tick();
        check("tmo2_not_yet", err,     1'b0);
        check("tmo2_req",     mem_req, 1'b1);
        drive(1'b1, 3'b001, 32'h0000_6001, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("tmo2_err",    err,      1'b1);
        check("tmo2_code",   err_code, 2'b11);
        check("tmo2_addr",   err_addr, 32'h0000_5004);
        check("tmo2_req_lo", mem_req,  1'b0);
        tick();
        check("pend_err",  err,      1'b1);
        check("pend_code", err_code, 2'b01);
        check("pend_addr", err_addr, 32'h0000_6001);
        tick();
        check("pend_pulse", err,      1'b0);
        check("pend_empty", sb_empty, 1'b1);

        // Reset while requesting with two entries buffered
        drive(1'b1, 3'b010, 32'h0000_7000, 32'h7777_0000);
        tick();
        drive(1'b1, 3'b010, 32'h0000_7004, 32'h7777_0004);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("mrst_req_before", mem_req,  1'b1);
        check("mrst_rdy_before", st_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_req",   mem_req,  1'b0);
        check("mrst_empty", sb_empty, 1'b1);
        check("mrst_rdy",   st_ready, 1'b1);
        check("mrst_err",   err,      1'b0);
        tick();
        tick();
        check("mrst_stays_idle", mem_req,  1'b0);
        check("mrst_no_err",     err,      1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
